sprite_fetch_arbiter: RTL
=========================

SPRITE_FETCH_ARBITER -- requirements
Module: sprite_fetch_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning sprite ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning sprite ROM data width (one sprite row).
REQ-003 The block SHALL have parameter ROM_LAT, default 1, legal 1..3, meaning sprite ROM read latency in cycles.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low; ports listed below.
REQ-005 clk  in  1  pixel clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 hblank  in  1  fetch window; new grants only while high.
REQ-008 req  in  3  single-cycle request pulses; bit0 pacman, bit1 blinky, bit2 pinky.
REQ-009 req_addr0, req_addr1, req_addr2  in  ADDR_W each  row address, captured with the matching req bit.
REQ-010 rom_rd  out  1  one-cycle ROM read strobe.
REQ-011 rom_addr  out  ADDR_W  ROM address, valid while rom_rd is high.
REQ-012 rom_data  in  DATA_W  ROM output, valid exactly ROM_LAT cycles after rom_rd.
REQ-013 grant  out  3  one-hot owner of the current fetch; zero when idle.
REQ-014 rsp_valid  out  3  one-hot, one-cycle pulse delivering rsp_data to its requester.
REQ-015 rsp_data  out  DATA_W  registered fetched row.
REQ-016 miss  out  1  one-cycle pulse when hblank falls with requests still pending.

Function
REQ-017 A req bit SHALL set the matching pending bit and load its address register in the same edge; a req while already pending SHALL overwrite the address and keep one pending entry.
REQ-018 The FSM SHALL have states IDLE, READ, WAIT and RESP.
REQ-019 In IDLE with hblank=1 and pending!=0, the block SHALL select a winner, set grant and rom_addr, and enter READ on the next edge.
REQ-020 READ SHALL last 1 cycle with rom_rd=1 and then go to WAIT.
REQ-021 WAIT SHALL last ROM_LAT cycles, counted by a down-counter; rom_data SHALL be registered into rsp_data on its final cycle, after which the FSM enters RESP.
REQ-022 RESP SHALL last 1 cycle: rsp_valid=grant, clear the winner's pending bit, return to IDLE with grant=0.
REQ-023 A req pulse for the winner during RESP SHALL win over the clear, leaving the bit pending.
REQ-024 Fetch turnaround SHALL be 3+ROM_LAT cycles from grant to the next possible grant.
REQ-025 hblank falling during READ/WAIT/RESP SHALL NOT abort the fetch; it completes and no new grant follows until hblank is high again.
REQ-026 On each hblank 1->0 transition, miss SHALL pulse if pending!=0 excluding the bit being served; pending bits are retained.
REQ-027 grant and rsp_valid SHALL never have more than one bit set.
REQ-028 Requests arriving with hblank=0 SHALL be accepted into pending.

Reset
REQ-029 With rst_n low, state=IDLE, pending=0, address registers=0, grant=0, rom_rd=0, rom_addr=0, rsp_valid=0, rsp_data=0, miss=0, WAIT counter=0 and round-robin pointer=2, all asynchronously.
REQ-030 Reset asserted mid-fetch SHALL discard the fetch with no rsp_valid; first grant after release follows REQ-019.

Configuration
REQ-031 With macro SPRITE_FETCH_RR_EN defined, the winner SHALL be the first pending bit searching upward (wrapping) from last-served+1; the pointer updates in RESP.
REQ-032 Without SPRITE_FETCH_RR_EN, the winner SHALL be fixed priority bit0 > bit1 > bit2, matching layer priority pacman > blinky > pinky, and the pointer SHALL be absent.

Verification
REQ-033 ROM_LAT=1, hblank=1, req=001, addr0=0x12 -> rom_rd with rom_addr=0x12 two cycles after req; rsp_valid=001 with rom data three cycles after rom_rd.
REQ-034 Simultaneous req=111 after reset, RR enabled -> service order 0,1,2; new req=111 issued right after -> order 0,1,2; RR disabled with bit0 re-requested every RESP -> bit0 always served first, bit2 starves.
REQ-035 req=100 with hblank=0 -> no rom_rd; hblank rises -> grant=100 next edge; hblank falls with 010 pending -> miss=1 for one cycle, 010 retained.
REQ-036 hblank drops during WAIT of ROM_LAT=3 fetch -> rsp_valid still pulses; no further rom_rd until hblank=1.
REQ-037 rst_n low during WAIT -> all outputs 0 immediately, no rsp_valid after release; req pulse on winner during RESP -> bit re-served.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// Sprite ROM fetch arbiter: three pulse requesters share one sprite ROM, and new fetches start only during hblank.
// Define SPRITE_FETCH_RR_EN for round-robin arbitration. The default build uses fixed priority bit0 > bit1 > bit2.
module sprite_fetch_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hblank,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [2:0]        grant,
  output logic [2:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              miss
);

  localparam int unsigned NREQ  = 3;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     pending_q, pending_d;
  logic [ADDR_W-1:0]   addr_q [NREQ];
  logic [ADDR_W-1:0]   addr_d [NREQ];
  logic [NREQ-1:0]     grant_q, grant_d;
  logic                rom_rd_q, rom_rd_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                miss_q, miss_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hblank_q, hblank_d;
  logic [NREQ-1:0]     win_oh;
  logic [1:0]          win_idx;
`ifdef SPRITE_FETCH_RR_EN
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          srch;
`endif

  // Winner selection from the currently pending set
  always_comb begin
    win_oh  = '0;
    win_idx = 2'd0;
`ifdef SPRITE_FETCH_RR_EN
    srch    = 2'd0;
    // Walk the search order backwards so the first hit in order is the last one assigned
    for (int k = 3; k >= 1; k--) begin
      srch = 2'((int'(ptr_q) + k) % 3);
      if (pending_q[srch]) win_idx = srch;
    end
`else
    if (pending_q[2]) win_idx = 2'd2;
    if (pending_q[1]) win_idx = 2'd1;
    if (pending_q[0]) win_idx = 2'd0;
`endif
    if (|pending_q) win_oh[win_idx] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    grant_d     = grant_q;
    rom_rd_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    cnt_d       = cnt_q;
    hblank_d    = hblank;
`ifdef SPRITE_FETCH_RR_EN
    ptr_d       = ptr_q;
`endif
    // The requester currently being served never counts as missed
    miss_d      = hblank_q & ~hblank & (|(pending_q & ~grant_q));

    case (state_q)
      S_IDLE: begin
        if (hblank && (|pending_q)) begin
          grant_d    = win_oh;
          rom_addr_d = addr_q[win_idx];
          rom_rd_d   = 1'b1;
          state_d    = S_READ;
        end
      end
      S_READ: begin
        cnt_d   = CNT_W'(ROM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = rom_data;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        rsp_valid_d = grant_q;
        pending_d   = pending_q & ~grant_q;
        grant_d     = '0;
        state_d     = S_IDLE;
`ifdef SPRITE_FETCH_RR_EN
        ptr_d       = grant_q[2] ? 2'd2 : (grant_q[1] ? 2'd1 : 2'd0);
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // A new request wins over the clear in RESP
    pending_d = pending_d | req;
    if (req[0]) addr_d[0] = req_addr0;
    if (req[1]) addr_d[1] = req_addr1;
    if (req[2]) addr_d[2] = req_addr2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      for (int i = 0; i < int'(NREQ); i++) addr_q[i] <= '0;
      grant_q     <= '0;
      rom_rd_q    <= 1'b0;
      rom_addr_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      miss_q      <= 1'b0;
      cnt_q       <= '0;
      hblank_q    <= 1'b0;
`ifdef SPRITE_FETCH_RR_EN
      ptr_q       <= 2'd2;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      addr_q      <= addr_d;
      grant_q     <= grant_d;
      rom_rd_q    <= rom_rd_d;
      rom_addr_q  <= rom_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      miss_q      <= miss_d;
      cnt_q       <= cnt_d;
      hblank_q    <= hblank_d;
`ifdef SPRITE_FETCH_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign rom_rd    = rom_rd_q;
  assign rom_addr  = rom_addr_q;
  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign miss      = miss_q;

endmodule
